// File: rtl/pc_psr_unit_pkg.sv
// Shared constants for the PC/PSR unit: flag bit positions, opcode fields, condition codes.
package pc_psr_unit_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_EXT    = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7,
    CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB,
    CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NC = 4'hF
  } cond_e;

  // Bcond, or the extended-opcode group with the Jcond sub-code.
  function automatic logic is_ctrl_xfer(input logic [15:0] instr);
    return (instr[15:12] == OP_BCOND) ||
           ((instr[15:12] == OP_EXT) && (instr[7:4] == EXT_JCOND));
  endfunction

endpackage

// File: rtl/pc_psr_unit_branch_cond.sv
// Combinational condition-code evaluator against the registered PSR flags.
module branch_cond
  import pc_psr_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic n, z, f, l, c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign f = flags[FLAG_F];
  assign l = flags[FLAG_L];
  assign c = flags[FLAG_C];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      CC_EQ:   taken = z;
      CC_NE:   taken = !z;
      CC_CS:   taken = c;
      CC_CC:   taken = !c;
      CC_HI:   taken = l;
      CC_LS:   taken = !l;
      CC_GT:   taken = n;
      CC_LE:   taken = !n;
      CC_FS:   taken = f;
      CC_FC:   taken = !f;
      CC_LO:   taken = !l && !z;
      CC_HS:   taken = l || z;
      CC_LT:   taken = !n && !z;
      CC_GE:   taken = n || z;
      CC_UC:   taken = 1'b1;
      CC_NC:   taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_psr_unit.sv
// Program counter and processor status register with conditional branch/jump.
// Optional feature macro PC_BRANCH_COUNT_EN adds a saturating 16-bit taken-branch counter.
module pc_psr_unit
  import pc_psr_unit_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pcEn,
  input  logic              pcIncOrSet,
  input  logic              psrEn,
  input  logic [15:0]       instruction,
  input  logic [4:0]        aluFlags,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [4:0]        psrFlags,
  output logic              branchTaken
`ifdef PC_BRANCH_COUNT_EN
  ,
  output logic [15:0]       branchCount
`endif
);

  logic ctrl_op;
  logic cond_true;
  logic take;
  logic unused_instr_bits;

  assign ctrl_op           = is_ctrl_xfer(instruction);
  assign unused_instr_bits = ^instruction[3:0];

  // Decision uses the registered PSR, so a same-edge PSR load cannot affect it.
  branch_cond u_cond (
    .cond  (instruction[11:8]),
    .flags (psrFlags),
    .taken (cond_true)
  );

  assign take = pcEn && pcIncOrSet && ctrl_op && cond_true;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      psrFlags    <= '0;
      branchTaken <= 1'b0;
    end else begin
      if (pcEn)
        pc <= take ? target : pc + ADDR_W'(1);
      // Control-transfer ops use the ALU for the address add; keep their flags out.
      if (psrEn && !ctrl_op)
        psrFlags <= aluFlags;
      branchTaken <= take;
    end
  end

`ifdef PC_BRANCH_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      branchCount <= '0;
    else if (take && (branchCount != 16'hFFFF))
      branchCount <= branchCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pc_psr_unit.sv
// Self-checking bench for pc_psr_unit: directed scenarios plus randomized traffic vs. a reference model.
module tb_pc_psr_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pcEn = 1'b0, pcIncOrSet = 1'b0, psrEn = 1'b0;
  logic [15:0] instruction = '0;
  logic [4:0]  aluFlags = '0;
  logic [15:0] target = '0;
  logic [15:0] pc;
  logic [4:0]  psrFlags;
  logic        branchTaken;
`ifdef PC_BRANCH_COUNT_EN
  logic [15:0] branchCount;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [15:0] m_pc;
  logic [4:0]  m_psr;
  logic        m_bt;
  logic [15:0] m_cnt;

  always #5 clock = ~clock;

  pc_psr_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .pcEn        (pcEn),
    .pcIncOrSet  (pcIncOrSet),
    .psrEn       (psrEn),
    .instruction (instruction),
    .aluFlags    (aluFlags),
    .target      (target),
    .pc          (pc),
    .psrFlags    (psrFlags),
    .branchTaken (branchTaken)
`ifdef PC_BRANCH_COUNT_EN
    ,
    .branchCount (branchCount)
`endif
  );

  function automatic logic m_is_ctrl(input logic [15:0] ins);
    return (ins[15:12] == 4'hC) || (ins[15:12] == 4'h4 && ins[7:4] == 4'hC);
  endfunction

  // truth table of all sixteen conditions, indexed by the condition code
  function automatic logic m_cond(input logic [3:0] cc, input logic [4:0] fl);
    logic n, z, f, l, c;
    logic [15:0] t;
    n = fl[4]; z = fl[3]; f = fl[2]; l = fl[1]; c = fl[0];
    t = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~f, f,
         ~n, n, ~l, l, ~c, c, ~z, z};
    return t[cc];
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_psr = '0; m_bt = 1'b0; m_cnt = '0;
  endtask

  task automatic model_edge();
    logic tk;
    if (!reset) begin
      model_reset();
    end else begin
      tk = pcEn && pcIncOrSet && m_is_ctrl(instruction) && m_cond(instruction[11:8], m_psr);
      if (pcEn) m_pc = tk ? target : m_pc + 16'd1;
      if (psrEn && !m_is_ctrl(instruction)) m_psr = aluFlags;
      m_bt = tk;
      if (tk && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  // one clock edge; inputs are left stable, sampling happens 1 time unit later
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic en, input logic inc, input logic pen,
                       input logic [15:0] ins, input logic [4:0] alu, input logic [15:0] tgt);
    pcEn = en; pcIncOrSet = inc; psrEn = pen; instruction = ins; aluFlags = alu; target = tgt;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #2;
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 16'h0000); end
    checks++; if (psrFlags !== 5'b0) begin failures++; $display("FAIL reset_psr got=%b exp=%b", psrFlags, 5'b0); end
    checks++; if (branchTaken !== 1'b0) begin failures++; $display("FAIL reset_bt got=%b exp=0", branchTaken); end
`ifdef PC_BRANCH_COUNT_EN
    checks++; if (branchCount !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", branchCount); end
`endif
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_increment();
    logic [15:0] exp_pc;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 5'b0, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_pc = 16'(i);
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL inc_pc%0d got=%h exp=%h", i, pc, exp_pc); end
      checks++; if (branchTaken !== 1'b0) begin failures++; $display("FAIL inc_bt%0d got=%b exp=0", i, branchTaken); end
    end
  endtask

  task automatic test_branch_eq();
    drive(1'b0, 1'b0, 1'b1, 16'h0B01, 5'b01000, 16'h0000);
    step();
    checks++; if (psrFlags !== 5'b01000) begin failures++; $display("FAIL eq_psr_load got=%b exp=01000", psrFlags); end
    // psrEn is held high during the branch: its flags must not land
    drive(1'b1, 1'b1, 1'b1, 16'hC012, 5'b00000, 16'h0040);
    step();
    checks++; if (pc !== 16'h0040) begin failures++; $display("FAIL eq_pc got=%h exp=0040", pc); end
    checks++; if (branchTaken !== 1'b1) begin failures++; $display("FAIL eq_bt got=%b exp=1", branchTaken); end
    checks++; if (psrFlags !== 5'b01000) begin failures++; $display("FAIL eq_psr_hold got=%b exp=01000", psrFlags); end
    drive(1'b0, 1'b1, 1'b0, 16'hC012, 5'b0, 16'h0040);
    step();
    checks++; if (branchTaken !== 1'b0) begin failures++; $display("FAIL eq_bt_pulse got=%b exp=0", branchTaken); end
    checks++; if (pc !== 16'h0040) begin failures++; $display("FAIL eq_pc_hold got=%h exp=0040", pc); end
  endtask

  task automatic test_branch_ne();
    drive(1'b1, 1'b1, 1'b0, 16'hC134, 5'b0, 16'h0040);
    step();
    checks++; if (pc !== 16'h0041) begin failures++; $display("FAIL ne_pc got=%h exp=0041", pc); end
    checks++; if (branchTaken !== 1'b0) begin failures++; $display("FAIL ne_bt got=%b exp=0", branchTaken); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 1'b0, 16'hCE00, 5'b0, 16'hFFFF);
    step();
    checks++; if (pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_setup got=%h exp=ffff", pc); end
    drive(1'b1, 1'b0, 1'b0, 16'hCE00, 5'b0, 16'h1234);
    step();
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
    checks++; if (branchTaken !== 1'b0) begin failures++; $display("FAIL wrap_bt got=%b exp=0", branchTaken); end
  endtask

  task automatic test_jcond();
    drive(1'b0, 1'b0, 1'b1, 16'h0B01, 5'b10000, 16'h0000);
    step();
    checks++; if (psrFlags !== 5'b10000) begin failures++; $display("FAIL jc_psr got=%b exp=10000", psrFlags); end
    drive(1'b1, 1'b1, 1'b0, 16'h46C3, 5'b0, 16'h1234);
    step();
    checks++; if (pc !== 16'h1234) begin failures++; $display("FAIL jc_gt_pc got=%h exp=1234", pc); end
    checks++; if (branchTaken !== 1'b1) begin failures++; $display("FAIL jc_gt_bt got=%b exp=1", branchTaken); end
    drive(1'b0, 1'b0, 1'b1, 16'h46C3, 5'b11111, 16'h0000);
    step();
    checks++; if (psrFlags !== 5'b10000) begin failures++; $display("FAIL jc_psr_hold got=%b exp=10000", psrFlags); end
    checks++; if (pc !== 16'h1234) begin failures++; $display("FAIL jc_pc_hold got=%h exp=1234", pc); end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       ins = {4'hC, 4'($urandom), 8'($urandom)};
        1:       ins = {4'h4, 4'($urandom), 4'hC, 4'($urandom)};
        2:       ins = {4'h4, 4'($urandom), 4'($urandom), 4'($urandom)};
        default: ins = 16'($urandom);
      endcase
      drive(1'($urandom), 1'($urandom), 1'($urandom), ins, 5'($urandom), 16'($urandom));
      step();
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, pc, m_pc); end
      checks++; if (psrFlags !== m_psr) begin failures++; $display("FAIL rnd_psr[%0d] got=%b exp=%b", i, psrFlags, m_psr); end
      checks++; if (branchTaken !== m_bt) begin failures++; $display("FAIL rnd_bt[%0d] got=%b exp=%b", i, branchTaken, m_bt); end
`ifdef PC_BRANCH_COUNT_EN
      checks++; if (branchCount !== m_cnt) begin failures++; $display("FAIL rnd_cnt[%0d] got=%h exp=%h", i, branchCount, m_cnt); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b0, 16'hCE00, 5'b0, 16'h0BAD);
    step();
    checks++; if (pc !== 16'h0BAD) begin failures++; $display("FAIL rm_setup got=%h exp=0bad", pc); end
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL rm_pc got=%h exp=0000", pc); end
    checks++; if (branchTaken !== 1'b0) begin failures++; $display("FAIL rm_bt got=%b exp=0", branchTaken); end
    checks++; if (psrFlags !== 5'b0) begin failures++; $display("FAIL rm_psr got=%b exp=0", psrFlags); end
`ifdef PC_BRANCH_COUNT_EN
    checks++; if (branchCount !== 16'h0) begin failures++; $display("FAIL rm_cnt got=%h exp=0000", branchCount); end
`endif
    step();
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL rm_hold got=%h exp=0000", pc); end
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 5'b0, 16'h0BAD);
    #3;
    reset = 1'b1;
    step();
    checks++; if (pc !== 16'h0001) begin failures++; $display("FAIL rm_first got=%h exp=0001", pc); end
    checks++; if (branchTaken !== 1'b0) begin failures++; $display("FAIL rm_first_bt got=%b exp=0", branchTaken); end
  endtask

`ifdef PC_BRANCH_COUNT_EN
  task automatic test_saturate();
    #3;
    reset = 1'b0;
    model_reset();
    #3;
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'hCE00, 5'b0, 16'h0100);
    for (int i = 0; i < 65534; i++) step();
    checks++; if (branchCount !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", branchCount); end
    step();
    checks++; if (branchCount !== 16'hFFFF) begin failures++; $display("FAIL sat_max got=%h exp=ffff", branchCount); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (branchCount !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", branchCount); end
    checks++; if (branchCount !== m_cnt) begin failures++; $display("FAIL sat_model got=%h exp=%h", branchCount, m_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_increment();
    test_branch_eq();
    test_branch_ne();
    test_wrap();
    test_jcond();
    test_random();
    test_reset_mid();
`ifdef PC_BRANCH_COUNT_EN
    test_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
